// File: rtl/q_update_engine.sv
// Q-learning update stage. It reads Q(s,a) and every Q(s',k), then writes
// Q(s,a) + alpha*(r + gamma*max Q(s',.) - Q(s,a)) back to the same table
// entry. It also reports the argmax action of s'.
//
// state | meaning
// IDLE  | o_ready high, waiting for a transition
// ISSUE | read Q(s,a), then Q(s',0..NA-1); k counts 0..NA
// DRAIN | last read datum (Q(s',NA-1)) arrives
// CALC  | compute the saturated update, load the write-port registers
// WRITE | o_write_en / o_done high for one cycle
module q_update_engine #(
  parameter int STATE_W  = 6,
  parameter int ACT_W    = 2,
  parameter int DATA_W   = 8,
  parameter int ALPHA_SH = 1,
  parameter int GAMMA_SH = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [STATE_W-1:0]         i_state,
  input  logic [ACT_W-1:0]           i_action,
  input  logic [DATA_W-1:0]          i_reward,
  input  logic [STATE_W-1:0]         i_next_state,
  output logic [STATE_W+ACT_W-1:0]   o_addr_r,
  input  logic [DATA_W-1:0]          i_q_data,
  output logic [STATE_W+ACT_W-1:0]   o_addr_w,
  output logic                       o_write_en,
  output logic [DATA_W-1:0]          o_wdata,
  output logic [ACT_W-1:0]           o_best_action,
  output logic                       o_done
);

  localparam int ADDR_W = STATE_W + ACT_W;
  localparam int NA     = 2 ** ACT_W;
  localparam int CW     = ACT_W + 1;
  localparam int IW     = DATA_W + 2;
  localparam logic signed [IW-1:0] Q_MAX = IW'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [IW-1:0] Q_MIN = IW'(-(2 ** (DATA_W - 1)));

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, CALC, WRITE} state_t;

  state_t                      state;
  logic [CW-1:0]               k;
  logic [STATE_W-1:0]          s_r;
  logic [STATE_W-1:0]          ns_r;
  logic [ACT_W-1:0]            a_r;
  logic signed [DATA_W-1:0]    r_r;
  logic signed [DATA_W-1:0]    q_cur;
  logic signed [DATA_W-1:0]    mx;
  logic [ACT_W-1:0]            best;

  logic signed [DATA_W-1:0]    q_in;
  logic [CW-1:0]               k_m2;
  logic signed [IW-1:0]        mx_x, q_x, r_x, g, td, d, n;
  logic [DATA_W-1:0]           n_sat;

  // Datapath for the update; all intermediates are sign-extended by two bits,
  // which covers the worst-case range of r + g - q_cur.
  always_comb begin
    q_in  = $signed(i_q_data);
    k_m2  = k - CW'(2);
    mx_x  = {{2{mx[DATA_W-1]}}, mx};
    q_x   = {{2{q_cur[DATA_W-1]}}, q_cur};
    r_x   = {{2{r_r[DATA_W-1]}}, r_r};
    g     = mx_x - (mx_x >>> GAMMA_SH);
    td    = r_x + g - q_x;
    d     = td >>> ALPHA_SH;
    n     = q_x + d;
    n_sat = n[DATA_W-1:0];
    if (n > Q_MAX)      n_sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (n < Q_MIN) n_sat = {1'b1, {(DATA_W-1){1'b0}}};
  end

  // Sequencer: read issue, running max/argmax, update and write strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      k             <= '0;
      s_r           <= '0;
      ns_r          <= '0;
      a_r           <= '0;
      r_r           <= '0;
      q_cur         <= '0;
      mx            <= '0;
      best          <= '0;
      o_ready       <= 1'b0;
      o_addr_r      <= '0;
      o_addr_w      <= '0;
      o_write_en    <= 1'b0;
      o_wdata       <= '0;
      o_best_action <= '0;
      o_done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid && o_ready) begin
            s_r      <= i_state;
            a_r      <= i_action;
            r_r      <= $signed(i_reward);
            ns_r     <= i_next_state;
            k        <= '0;
            o_addr_r <= {i_state, i_action};
            o_ready  <= 1'b0;
            state    <= ISSUE;
          end else begin
            o_ready <= 1'b1;
          end
        end
        ISSUE: begin
          // Address for the next cycle; the datum arriving now is from k-1.
          if (k < CW'(NA)) o_addr_r <= {ns_r, k[ACT_W-1:0]};
          if (k == CW'(1)) q_cur <= q_in;
          if (k >= CW'(2)) begin
            if ((k == CW'(2)) || (q_in > mx)) begin
              mx   <= q_in;
              best <= k_m2[ACT_W-1:0];
            end
          end
          if (k == CW'(NA)) state <= DRAIN;
          else              k     <= k + CW'(1);
        end
        DRAIN: begin
          // Strict compare keeps the lowest index on ties.
          if (q_in > mx) begin
            mx   <= q_in;
            best <= ACT_W'(NA - 1);
          end
          state <= CALC;
        end
        CALC: begin
          o_wdata       <= n_sat;
          o_addr_w      <= {s_r, a_r};
          o_best_action <= best;
          o_write_en    <= 1'b1;
          o_done        <= 1'b1;
          state         <= WRITE;
        end
        WRITE: begin
          o_write_en <= 1'b0;
          o_done     <= 1'b0;
          o_ready    <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q_update_engine.sv
// Bench for q_update_engine: behavioural Q-table BRAM, reference model feeding
// an expectation queue, and a write-port monitor that pops and compares.
module tb_q_update_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic       ready;
  logic [5:0] st = '0;
  logic [1:0] act = '0;
  logic [7:0] rew = '0;
  logic [5:0] nst = '0;
  logic [7:0] addr_r;
  logic [7:0] q_data = '0;
  logic [7:0] addr_w;
  logic       write_en;
  logic [7:0] wdata;
  logic [1:0] best_action;
  logic       done;

  logic [7:0] mem [256];
  int         n_checks = 0;
  int         n_errors = 0;
  int         wr_cnt = 0;

  typedef struct {
    logic [7:0] addr;
    int         data;
    int         best;
  } exp_t;
  exp_t exp_q[$];

  q_update_engine dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
    .i_state(st), .i_action(act), .i_reward(rew), .i_next_state(nst),
    .o_addr_r(addr_r), .i_q_data(q_data), .o_addr_w(addr_w),
    .o_write_en(write_en), .o_wdata(wdata), .o_best_action(best_action),
    .o_done(done)
  );

  always #5 clk = ~clk;

  // Q-table: one-cycle read latency, write on strobe.
  always @(posedge clk) begin
    q_data <= mem[addr_r];
    if (write_en) begin
      mem[addr_w] <= wdata;
      wr_cnt++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Scoreboard consumer: every write strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (done !== write_en) chk("done_eq_we", int'(done), int'(write_en));
    if (write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", int'(addr_w), int'(e.addr));
        chk("wr_data", int'($signed(wdata)), e.data);
        chk("best_action", int'(best_action), e.best);
        chk("done", int'(done), 1);
      end
    end
  end

  task automatic set_q(input logic [5:0] s, input logic [1:0] a, input int v);
    mem[{s, a}] = 8'(v);
  endtask

  // Reference: alpha = 1/2, gamma = 1/2, floor shifts, saturate to 8 bits.
  task automatic push_expect(input logic [5:0] s, input logic [1:0] a,
                             input int r, input logic [5:0] ns);
    exp_t e;
    int mx, bi, q, g, td, d, n;
    logic [1:0] kk;
    mx = $signed(mem[{ns, 2'b00}]);
    bi = 0;
    for (int k = 1; k < 4; k++) begin
      kk = k[1:0];
      if ($signed(mem[{ns, kk}]) > mx) begin
        mx = $signed(mem[{ns, kk}]);
        bi = k;
      end
    end
    q  = $signed(mem[{s, a}]);
    g  = mx - (mx >>> 1);
    td = r + g - q;
    d  = td >>> 1;
    n  = q + d;
    if (n > 127)  n = 127;
    if (n < -128) n = -128;
    e.addr = {s, a};
    e.data = n;
    e.best = bi;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready(input string tag);
    int guard = 0;
    while (ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (ready !== 1'b1) chk(tag, 0, 1);
  endtask

  task automatic run_txn(input logic [5:0] s, input logic [1:0] a,
                         input int r, input logic [5:0] ns);
    @(negedge clk);
    st = s; act = a; rew = 8'(r); nst = ns; valid = 1'b1;
    wait_ready("accept_timeout");
    push_expect(s, a, r, ns);
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while ((exp_q.size() != 0 || ready !== 1'b1) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) chk("done_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int  lowcnt, wc0;
    time t_prev, t_acc;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(ready), 0);
    chk("rst_we", int'(write_en), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addr_r", int'(addr_r), 0);
    chk("rst_addr_w", int'(addr_w), 0);
    chk("rst_wdata", int'(wdata), 0);
    chk("rst_best", int'(best_action), 0);
    rst = 1'b0;
    #1 chk("ready_before_edge", int'(ready), 0);
    @(posedge clk);
    #1 chk("ready_after_edge", int'(ready), 1);

    // Basic update, tie on max
    set_q(3, 1, 10);
    set_q(7, 0, 4); set_q(7, 1, 20); set_q(7, 2, -6); set_q(7, 3, 20);
    run_txn(3, 1, 8, 7);
    wait_done();
    chk("basic_mem", int'($signed(mem[{6'd3, 2'd1}])), 14);

    // Positive saturation
    set_q(9, 0, 120);
    for (int k = 0; k < 4; k++) mem[{6'd11, k[1:0]}] = 8'd127;
    run_txn(9, 0, 127, 11);
    wait_done();
    chk("pos_sat_mem", int'($signed(mem[{6'd9, 2'd0}])), 127);

    // Negative saturation
    set_q(12, 3, -120);
    for (int k = 0; k < 4; k++) mem[{6'd13, k[1:0]}] = 8'h80;
    run_txn(12, 3, -128, 13);
    wait_done();
    chk("neg_sat_mem", int'($signed(mem[{6'd12, 2'd3}])), -128);

    // Self-loop s == s'
    set_q(5, 0, 0); set_q(5, 1, 0); set_q(5, 2, 40); set_q(5, 3, 0);
    run_txn(5, 2, 0, 5);
    wait_done();
    chk("self_loop_mem", int'($signed(mem[{6'd5, 2'd2}])), 30);

    // Handshake: valid held high, back-to-back transactions
    set_q(20, 3, 0);
    set_q(21, 0, 1); set_q(21, 1, 2); set_q(21, 2, 3); set_q(21, 3, 4);
    @(negedge clk);
    st = 20; act = 3; rew = 8'd10; nst = 21; valid = 1'b1;
    t_prev = 0;
    for (int n = 0; n < 3; n++) begin
      wait_ready("hs_accept_timeout");
      push_expect(20, 3, 10, 21);
      @(posedge clk);
      t_acc = $time;
      if (n > 0) chk("hs_period", int'(t_acc - t_prev), 90);
      t_prev = t_acc;
      lowcnt = 0;
      for (int j = 0; j < 5; j++) begin
        @(negedge clk);
        if (ready === 1'b0) lowcnt++;
        if (j == 0) chk("hs_addr_sa", int'(addr_r), int'({6'd20, 2'd3}));
        else        chk("hs_addr_ns", int'(addr_r), int'({6'd21, 2'(j - 1)}));
      end
      while (ready !== 1'b1 && lowcnt < 40) begin
        @(negedge clk);
        if (ready === 1'b0) lowcnt++;
      end
      chk("hs_ready_low", lowcnt, 8);
    end
    valid = 1'b0;
    wait_done();

    // Reset mid-operation
    set_q(30, 0, 50);
    set_q(31, 0, 10); set_q(31, 1, 10); set_q(31, 2, 10); set_q(31, 3, 10);
    @(negedge clk);
    st = 30; act = 0; rew = 8'd20; nst = 31; valid = 1'b1;
    wait_ready("rst_accept_timeout");
    @(posedge clk);
    #1 valid = 1'b0;
    wc0 = wr_cnt;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("midrst_we", int'(write_en), 0);
    chk("midrst_ready", int'(ready), 0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_ready_hold", int'(ready), 0);
    end
    rst = 1'b0;
    #1 chk("rel_ready_before", int'(ready), 0);
    @(posedge clk);
    #1 chk("rel_ready_after", int'(ready), 1);
    repeat (10) @(posedge clk);
    chk("midrst_no_write", wr_cnt, wc0);
    chk("midrst_mem_kept", int'($signed(mem[{6'd30, 2'd0}])), 50);
    run_txn(30, 0, 20, 31);
    wait_done();

    // Random transactions
    for (int t = 0; t < 6; t++) begin
      logic [5:0] s, ns;
      logic [1:0] a;
      s  = 6'($urandom_range(32, 63));
      ns = 6'($urandom_range(32, 63));
      a  = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) mem[{ns, k[1:0]}] = 8'($urandom);
      set_q(s, a, int'($signed(8'($urandom))));
      run_txn(s, a, int'($signed(8'($urandom))), ns);
      wait_done();
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
